ioctl_upload_ctrl: RTL and testbench

- Serves the host side of the ioctl upload path. The framework reads core memory (cartridge/system RAM save, debug dump) one byte at a time.
- On each host read strobe it fetches the byte from a synchronous-read memory port, holds ioctl_wait until the data is valid, then presents the byte on ioctl_din.
- Counterpart of the download path: download writes memory, this block reads it back out.
- Sits between the framework ioctl bus and a RAM read port inside rcastudioii.

---
 rtl/ioctl_upload_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ioctl_upload_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_upload_ctrl.sv
// Host-side ioctl upload controller: reads core memory one byte per host strobe.
// Optional running checksum output when IOCTL_UPLOAD_CHECKSUM_EN is defined.
module ioctl_upload_ctrl #(
    parameter int         ADDR_W       = 12,
    parameter int         MEM_LAT      = 1,
    parameter logic [7:0] UPLOAD_INDEX = 8'h01,
    parameter logic [7:0] FILL_BYTE    = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_index,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_q,
    output logic              upload_active,
    output logic              upload_done,
    output logic [ADDR_W:0]   byte_count
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
    ,
    output logic [7:0]        checksum
`endif
);

    // state | meaning
    // IDLE  | waiting for a host strobe
    // FETCH | memory read issued, latency counter running toward mem_q valid
    // OOR   | address beyond memory, FILL_BYTE returned on the next edge
    typedef enum logic [1:0] {IDLE, FETCH, OOR} state_t;

    state_t            state_q, state_d;
    logic [2:0]        lat_q, lat_d;
    logic [7:0]        din_q, din_d;
    logic              wait_q, wait_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic              mrd_q, mrd_d;
    logic              sel_q, sel_d;
    logic              done_q, done_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
    logic [7:0]        cks_q, cks_d;
`endif

    logic       sel;
    logic       in_range;
    logic       sess_start;
    logic       deliver;
    logic [7:0] deliver_byte;

    assign sel        = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
    assign in_range   = ioctl_addr < (25'd1 << ADDR_W);
    assign sess_start = sel && !sel_q;

    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        din_d        = din_q;
        wait_d       = wait_q;
        maddr_d      = maddr_q;
        mrd_d        = 1'b0;
        sel_d        = sel;
        done_d       = sel_q && !sel;
        cnt_d        = cnt_q;
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
        cks_d        = cks_q;
`endif
        deliver      = 1'b0;
        deliver_byte = din_q;

        case (state_q)
            IDLE: begin
                if (ioctl_rd && sel) begin
                    wait_d = 1'b1;
                    if (in_range) begin
                        maddr_d = ioctl_addr[ADDR_W-1:0];
                        mrd_d   = 1'b1;
                        lat_d   = 3'(MEM_LAT);
                        state_d = FETCH;
                    end else begin
                        state_d = OOR;
                    end
                end
            end
            FETCH: begin
                // Terminal count marks the cycle in which mem_q is valid.
                if (lat_q == 3'd0) begin
                    deliver      = 1'b1;
                    deliver_byte = mem_q;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            OOR: begin
                deliver      = 1'b1;
                deliver_byte = FILL_BYTE;
            end
            default: state_d = IDLE;
        endcase

        if (deliver) begin
            din_d   = deliver_byte;
            wait_d  = 1'b0;
            state_d = IDLE;
        end

        // A new session clears the counters even if a stale read lands on the same edge.
        if (sess_start) begin
            cnt_d = '0;
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
            cks_d = 8'h00;
`endif
        end else if (deliver) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
            cks_d = cks_q + deliver_byte;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lat_q   <= 3'd0;
            din_q   <= 8'h00;
            wait_q  <= 1'b0;
            maddr_q <= '0;
            mrd_q   <= 1'b0;
            sel_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
            cks_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            din_q   <= din_d;
            wait_q  <= wait_d;
            maddr_q <= maddr_d;
            mrd_q   <= mrd_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
            cks_q   <= cks_d;
`endif
        end
    end

    assign ioctl_din     = din_q;
    assign ioctl_wait    = wait_q;
    assign mem_addr      = maddr_q;
    assign mem_rd        = mrd_q;
    assign upload_active = sel_q;
    assign upload_done   = done_q;
    assign byte_count    = cnt_q;
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
    assign checksum      = cks_q;
`endif

endmodule

// File: tb/tb_ioctl_upload_ctrl.sv
// Bench for ioctl_upload_ctrl: one instance at MEM_LAT=1 (vector table and corner
// sequences) and one at MEM_LAT=3 (sequential reads), each with its own memory model.
module tb_ioctl_upload_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        upl1, rd1, wait1, mrd1, act1, done1;
    logic [24:0] addr1;
    logic [7:0]  idx1, din1, q1;
    logic [11:0] maddr1;
    logic [12:0] cnt1;
    logic        upl3, rd3, wait3, mrd3, act3, done3;
    logic [24:0] addr3;
    logic [7:0]  idx3, din3, q3;
    logic [11:0] maddr3;
    logic [12:0] cnt3;
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
    logic [7:0]  cks1, cks3;
`endif

    ioctl_upload_ctrl #(.ADDR_W(12), .MEM_LAT(1), .UPLOAD_INDEX(8'h01), .FILL_BYTE(8'hFF)) dut1 (
        .clk(clk), .reset(reset), .ioctl_upload(upl1), .ioctl_rd(rd1), .ioctl_addr(addr1),
        .ioctl_index(idx1), .ioctl_din(din1), .ioctl_wait(wait1), .mem_addr(maddr1),
        .mem_rd(mrd1), .mem_q(q1), .upload_active(act1), .upload_done(done1),
        .byte_count(cnt1)
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
        , .checksum(cks1)
`endif
    );

    ioctl_upload_ctrl #(.ADDR_W(12), .MEM_LAT(3), .UPLOAD_INDEX(8'h01), .FILL_BYTE(8'hFF)) dut3 (
        .clk(clk), .reset(reset), .ioctl_upload(upl3), .ioctl_rd(rd3), .ioctl_addr(addr3),
        .ioctl_index(idx3), .ioctl_din(din3), .ioctl_wait(wait3), .mem_addr(maddr3),
        .mem_rd(mrd3), .mem_q(q3), .upload_active(act3), .upload_done(done3),
        .byte_count(cnt3)
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
        , .checksum(cks3)
`endif
    );

    // Memory models: data appears exactly MEM_LAT cycles after mem_rd, junk otherwise.
    logic [7:0] mem1 [0:4095];
    logic [7:0] mem3 [0:4095];
    logic [7:0] p1;
    logic [7:0] p3 [0:2];
    always @(posedge clk) begin
        p1    <= mrd1 ? mem1[maddr1] : 8'h3C;
        p3[0] <= mrd3 ? mem3[maddr3] : 8'h3C;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign q1 = p1;
    assign q3 = p3[2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        upl;
        logic [7:0]  idx;
        logic        rd;
        logic [24:0] addr;
        logic        act;
        logic        wt;
        logic        mrd;
        logic [11:0] maddr;
        logic [7:0]  din;
        logic [12:0] cnt;
        logic        done;
        logic [7:0]  cks;
    } vec_t;

    function automatic vec_t mk(logic upl, logic [7:0] idx, logic rd, logic [24:0] addr,
                                logic act, logic wt, logic mrd, logic [11:0] maddr,
                                logic [7:0] din, logic [12:0] cnt, logic done, logic [7:0] cks);
        vec_t v;
        v.upl = upl; v.idx = idx; v.rd = rd; v.addr = addr;
        v.act = act; v.wt = wt; v.mrd = mrd; v.maddr = maddr;
        v.din = din; v.cnt = cnt; v.done = done; v.cks = cks;
        return v;
    endfunction

    vec_t vt [16];

    initial begin
        int n;
        int pulses;
        logic [7:0] exp3 [0:3];

        for (int i = 0; i < 4096; i++) begin
            mem1[i] = 8'h00;
            mem3[i] = 8'h00;
        end
        mem1[0] = 8'hA5; mem1[5] = 8'h26; mem1[12'hFFF] = 8'hFC;
        mem3[0] = 8'h11; mem3[1] = 8'h22; mem3[2] = 8'h33; mem3[3] = 8'h44;
        exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33; exp3[3] = 8'h44;

        //            upl idx    rd addr        act wt mrd maddr    din    cnt     done cks
        vt[0]  = mk(1, 8'h01, 0, 25'h0,      1, 0, 0, 12'h000, 8'h00, 13'd0, 0, 8'h00);
        vt[1]  = mk(1, 8'h01, 1, 25'h0,      1, 1, 1, 12'h000, 8'h00, 13'd0, 0, 8'h00);
        vt[2]  = mk(1, 8'h01, 0, 25'h0,      1, 1, 0, 12'h000, 8'h00, 13'd0, 0, 8'h00);
        vt[3]  = mk(1, 8'h01, 0, 25'h0,      1, 0, 0, 12'h000, 8'hA5, 13'd1, 0, 8'hA5);
        vt[4]  = mk(1, 8'h01, 1, 25'h1000,   1, 1, 0, 12'h000, 8'hA5, 13'd1, 0, 8'hA5);
        vt[5]  = mk(1, 8'h01, 0, 25'h0,      1, 0, 0, 12'h000, 8'hFF, 13'd2, 0, 8'hA4);
        vt[6]  = mk(1, 8'h01, 1, 25'h5,      1, 1, 1, 12'h005, 8'hFF, 13'd2, 0, 8'hA4);
        vt[7]  = mk(1, 8'h01, 1, 25'hFFF,    1, 1, 0, 12'h005, 8'hFF, 13'd2, 0, 8'hA4);
        vt[8]  = mk(1, 8'h01, 1, 25'hFFF,    1, 0, 0, 12'h005, 8'h26, 13'd3, 0, 8'hCA);
        vt[9]  = mk(1, 8'h02, 1, 25'hFFF,    0, 0, 0, 12'h005, 8'h26, 13'd3, 1, 8'hCA);
        vt[10] = mk(1, 8'h01, 0, 25'h0,      1, 0, 0, 12'h005, 8'h26, 13'd0, 0, 8'h00);
        vt[11] = mk(1, 8'h01, 1, 25'hFFF,    1, 1, 1, 12'hFFF, 8'h26, 13'd0, 0, 8'h00);
        vt[12] = mk(0, 8'h01, 0, 25'h0,      0, 1, 0, 12'hFFF, 8'h26, 13'd0, 1, 8'h00);
        vt[13] = mk(0, 8'h01, 0, 25'h0,      0, 0, 0, 12'hFFF, 8'hFC, 13'd1, 0, 8'hFC);
        vt[14] = mk(0, 8'h01, 1, 25'h0,      0, 0, 0, 12'hFFF, 8'hFC, 13'd1, 0, 8'hFC);
        vt[15] = mk(1, 8'h01, 0, 25'h0,      1, 0, 0, 12'hFFF, 8'hFC, 13'd0, 0, 8'h00);

        reset = 1'b1;
        upl1 = 0; rd1 = 0; addr1 = '0; idx1 = 8'h01;
        upl3 = 0; rd3 = 0; addr3 = '0; idx3 = 8'h01;
        tick(); tick();
        chk("rst_din", din1, 8'h00);
        chk("rst_wait", wait1, 1'b0);
        chk("rst_mrd", mrd1, 1'b0);
        chk("rst_maddr", maddr1, 12'h000);
        chk("rst_act", act1, 1'b0);
        chk("rst_done", done1, 1'b0);
        chk("rst_cnt", cnt1, 13'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            upl1 = vt[i].upl; idx1 = vt[i].idx; rd1 = vt[i].rd; addr1 = vt[i].addr;
            tick();
            chk($sformatf("v%0d_act", i), act1, vt[i].act);
            chk($sformatf("v%0d_wait", i), wait1, vt[i].wt);
            chk($sformatf("v%0d_mrd", i), mrd1, vt[i].mrd);
            chk($sformatf("v%0d_maddr", i), maddr1, vt[i].maddr);
            chk($sformatf("v%0d_din", i), din1, vt[i].din);
            chk($sformatf("v%0d_cnt", i), cnt1, vt[i].cnt);
            chk($sformatf("v%0d_done", i), done1, vt[i].done);
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
            chk($sformatf("v%0d_cks", i), cks1, vt[i].cks);
`endif
        end
        rd1 = 0;

        // Reset in the middle of a fetch, then an immediate re-strobe.
        rd1 = 1; addr1 = 25'h0;
        tick();
        rd1 = 0;
        chk("rf_wait_pre", wait1, 1'b1);
        chk("rf_mrd_pre", mrd1, 1'b1);
        reset = 1'b1;
        tick();
        chk("rf_wait", wait1, 1'b0);
        chk("rf_din", din1, 8'h00);
        chk("rf_cnt", cnt1, 13'd0);
        chk("rf_mrd", mrd1, 1'b0);
        reset = 1'b0;
        rd1 = 1; addr1 = 25'h0;
        tick();
        rd1 = 0;
        chk("rf2_mrd", mrd1, 1'b1);
        chk("rf2_wait1", wait1, 1'b1);
        tick();
        chk("rf2_wait2", wait1, 1'b1);
        chk("rf2_din_hold", din1, 8'h00);
        tick();
        chk("rf2_wait_end", wait1, 1'b0);
        chk("rf2_din", din1, 8'hA5);
        chk("rf2_cnt", cnt1, 13'd1);

        // MEM_LAT=3 sequential reads.
        upl3 = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            rd3 = 1; addr3 = 25'(i);
            tick();
            rd3 = 0;
            n = 0; pulses = 0;
            while (wait3 && n < 20) begin
                n++;
                if (mrd3) pulses++;
                tick();
            end
            chk($sformatf("l3_wait_cycles%0d", i), n, 4);
            chk($sformatf("l3_mrd_pulses%0d", i), pulses, 1);
            chk($sformatf("l3_din%0d", i), din3, exp3[i]);
        end
        chk("l3_cnt", cnt3, 13'd4);
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
        chk("l3_cks", cks3, 8'hAA);
`endif

        // byte_count saturation via out-of-range reads (count currently 1).
        addr1 = 25'h1FF_FFFF;
        for (int i = 0; i < 8189; i++) begin
            rd1 = 1; tick(); rd1 = 0; tick();
        end
        chk("sat_cnt_pre", cnt1, 13'd8190);
        chk("sat_din", din1, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            rd1 = 1; tick(); rd1 = 0; tick();
        end
        chk("sat_cnt", cnt1, 13'h1FFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
